// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the core execute stage to a word-addressed data memory. RV32I
// byte/half/word loads and stores are turned into aligned word accesses:
// loads are lane-selected and sign/zero-extended, and sub-word stores go
// through a read-modify-write so the untouched bytes of the word survive.
// The memory reads combinationally and writes on the rising clock edge.
//
// Optional feature (compile-time macro): LSU_ALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/SH/LW/SW are rejected with resp_error.
//   undefined : low address bits are forced to the natural alignment and the
//               access proceeds; only illegal funct3 raises resp_error.
//
// Ports
//   clk               system clock, all state on posedge
//   rst_en            synchronous reset, active-high
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr          byte address
//   req_wdata         store data (low byte/half used for SB/SH)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data, 0 for stores and errors
//   resp_error        illegal request flag, qualified by resp_valid
//   mem_address       word address to memory, bits [1:0] always 00
//   mem_write_data    full word to memory
//   mem_write_enable  memory write strobe
//   mem_read_data     combinational read of mem_address
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

  // Overlay the store byte/half on the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] m;
    m = word;
    if (f3 == F3_H) m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else            m[{lane, 3'b000} +: 8]      = wdata[7:0];
    return m;
  endfunction

  state_t            state;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we_q;

  logic              illegal_f3;
  logic              req_err;
  logic [ADDR_W-1:0] req_addr_nat;
  logic [ADDR_W-1:0] word_addr;

  // Request decode. Halves and words get their low address bits cleared so
  // that, with alignment checking off, the access lands on the natural lane.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    illegal_f3   = 1'b0;
    req_addr_nat = req_addr;
    case (req_funct3)
      F3_B, F3_BU: ;
      F3_H, F3_HU: req_addr_nat[0]   = 1'b0;
      F3_W:        req_addr_nat[1:0] = 2'b00;
      default:     illegal_f3        = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (req_we && req_funct3[2]) illegal_f3 = 1'b1;
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign req_err = illegal_f3 | misaligned;
`else
  assign req_err = illegal_f3;
`endif

  assign word_addr = {req_addr_nat[ADDR_W-1:2], 2'b00};
  assign req_ready = (state == IDLE);

  // The strobe is masked by reset so a reset landing on a write cycle
  // cannot corrupt memory.
  assign mem_write_enable = mem_we_q & ~rst_en;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_en) begin
      state          <= IDLE;
      f3_q           <= 3'b000;
      addr_q         <= '0;
      wdata_q        <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_we_q       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q       <= req_funct3;
            addr_q     <= req_addr_nat;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            if (req_err) begin
              // Rejected requests never touch memory.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (!req_we) begin
              state       <= LOAD;
              mem_address <= word_addr;
            end else if (req_funct3 == F3_W) begin
              state          <= STORE;
              mem_address    <= word_addr;
              mem_write_data <= req_wdata;
              mem_we_q       <= 1'b1;
            end else begin
              state       <= RMW_RD;
              mem_address <= word_addr;
            end
          end
        end

        LOAD: begin
          resp_rdata  <= load_extend(mem_read_data, addr_q[1:0], f3_q);
          mem_address <= '0;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end

        RMW_RD: begin
          // Address is held; the merged word is written on the next edge.
          mem_write_data <= store_merge(mem_read_data, wdata_q, addr_q[1:0], f3_q);
          mem_we_q       <= 1'b1;
          state          <= RMW_WR;
        end

        STORE, RMW_WR: begin
          mem_address    <= '0;
          mem_write_data <= '0;
          mem_we_q       <= 1'b0;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end

        RESP: begin
          resp_rdata <= '0;
          resp_error <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed self-checking bench for load_store_unit. A 64-word memory with a
// combinational read and posedge write stands in for the data RAM. Each
// scenario task drives requests and compares against hand-computed values.
// Build with or without +define+LSU_ALIGN_CHECK_EN; expectations follow.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_load_store_unit;

  logic        clk;
  logic        rst_en;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int wr_count  = 0;
  int addr_viol = 0;

  logic [31:0] mem [0:63];

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_en           (rst_en),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[7:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_address[1:0] != 2'b00) addr_viol = addr_viol + 1;
  end

  // Issue one request from a negedge and wait (bounded) for its response.
  // Returns at the negedge where resp_valid was seen; lat = -1 on timeout.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat   = i;
        rdata = resp_rdata;
        err   = resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_en     = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0)
      $display("FAIL reset_resp: got valid=%b err=%b rdata=%h expected 0/0/0",
               resp_valid, resp_error, resp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (mem_address !== 32'h0 || mem_write_data !== 32'h0 || mem_write_enable !== 1'b0)
      $display("FAIL reset_mem: got addr=%h wdata=%h we=%b expected 0/0/0",
               mem_address, mem_write_data, mem_write_enable);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_en = 1'b0;
  endtask

  // Reset arriving during the write cycle of an SB must suppress the write.
  task automatic test_reset_mid_rmw();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wr_before;
    int          stray;
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, er, lat);
    total_cnt++;
    if (mem[8] !== 32'h1122_3344) $display("FAIL rst_preload: got %h expected 11223344", mem[8]);
    else pass_cnt++;
    wr_before = wr_count;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h0000_00AA;
    req_valid = 1'b1;
    @(posedge clk);            // accept -> RMW_RD
    #1 req_valid = 1'b0;
    @(posedge clk);            // -> RMW_WR
    #1 rst_en = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (mem_write_enable !== 1'b0) $display("FAIL rst_we_gate: got %b expected 0", mem_write_enable);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL rst_mid_state: got ready=%b valid=%b expected 1/0", req_ready, resp_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_en = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    total_cnt++;
    if (stray != 0) $display("FAIL rst_no_resp: got %0d responses expected 0", stray);
    else pass_cnt++;
    total_cnt++;
    if (mem[8] !== 32'h1122_3344 || wr_count != wr_before)
      $display("FAIL rst_no_write: got word=%h writes=%0d expected 11223344 writes=%0d",
               mem[8], wr_count, wr_before);
    else pass_cnt++;
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    total_cnt++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0)
      $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h expected 2/0/00000000", lat, er, rd);
    else pass_cnt++;
    total_cnt++;
    if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL sw_word: got %h expected deadbeef", mem[4]);
    else pass_cnt++;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    total_cnt++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF)
      $display("FAIL lw_resp: got lat=%0d err=%b rdata=%h expected 2/0/deadbeef", lat, er, rd);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL resp_pulse: got %b expected 0", resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_byte();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 3'b000, 32'h13, 32'h1234_5680, rd, er, lat);
    total_cnt++;
    if (lat != 3 || er !== 1'b0) $display("FAIL sb_resp: got lat=%0d err=%b expected 3/0", lat, er);
    else pass_cnt++;
    total_cnt++;
    if (mem[4] !== 32'h80AD_BEEF) $display("FAIL sb_word: got %h expected 80adbeef", mem[4]);
    else pass_cnt++;
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
    total_cnt++;
    if (lat != 2 || rd !== 32'hFFFF_FF80) $display("FAIL lb_sign: got lat=%0d rdata=%h expected 2/ffffff80", lat, rd);
    else pass_cnt++;
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    total_cnt++;
    if (lat != 2 || rd !== 32'h0000_0080) $display("FAIL lbu_zero: got lat=%0d rdata=%h expected 2/00000080", lat, rd);
    else pass_cnt++;
    do_req(1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'hFFFF_FFBE) $display("FAIL lb_lane1: got %h expected ffffffbe", rd);
    else pass_cnt++;
  endtask

  task automatic test_half();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 3'b001, 32'h12, 32'hABCD_1234, rd, er, lat);
    total_cnt++;
    if (lat != 3 || er !== 1'b0) $display("FAIL sh_resp: got lat=%0d err=%b expected 3/0", lat, er);
    else pass_cnt++;
    total_cnt++;
    if (mem[4] !== 32'h1234_BEEF) $display("FAIL sh_word: got %h expected 1234beef", mem[4]);
    else pass_cnt++;
    do_req(1'b0, 3'b001, 32'h10, 32'h0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'hFFFF_BEEF) $display("FAIL lh_sign: got %h expected ffffbeef", rd);
    else pass_cnt++;
    do_req(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'h0000_BEEF) $display("FAIL lhu_zero: got %h expected 0000beef", rd);
    else pass_cnt++;
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'h0000_1234) $display("FAIL lh_upper: got %h expected 00001234", rd);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wr_before;
    logic [31:0] addr_at_resp;
    wr_before = wr_count;
    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat);
    addr_at_resp = mem_address;
`ifdef LSU_ALIGN_CHECK_EN
    total_cnt++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'h0)
      $display("FAIL lw_misalign: got lat=%0d err=%b rdata=%h expected 1/1/00000000", lat, er, rd);
    else pass_cnt++;
    total_cnt++;
    if (addr_at_resp !== 32'h0) $display("FAIL misalign_noaccess: got addr=%h expected 00000000", addr_at_resp);
    else pass_cnt++;
    do_req(1'b1, 3'b001, 32'h13, 32'h0000_5678, rd, er, lat);
    total_cnt++;
    if (lat != 1 || er !== 1'b1 || mem[4] !== 32'h1234_BEEF || wr_count != wr_before)
      $display("FAIL sh_misalign: got lat=%0d err=%b word=%h writes=%0d expected 1/1/1234beef/%0d",
               lat, er, mem[4], wr_count, wr_before);
    else pass_cnt++;
`else
    total_cnt++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h1234_BEEF)
      $display("FAIL lw_misalign: got lat=%0d err=%b rdata=%h expected 2/0/1234beef", lat, er, rd);
    else pass_cnt++;
    total_cnt++;
    if (addr_at_resp !== 32'h0) $display("FAIL resp_addr_idle: got addr=%h expected 00000000", addr_at_resp);
    else pass_cnt++;
    do_req(1'b1, 3'b001, 32'h13, 32'h0000_5678, rd, er, lat);
    total_cnt++;
    if (lat != 3 || er !== 1'b0 || mem[4] !== 32'h5678_BEEF || wr_count != wr_before + 1)
      $display("FAIL sh_misalign: got lat=%0d err=%b word=%h writes=%0d expected 3/0/5678beef/%0d",
               lat, er, mem[4], wr_count, wr_before + 1);
    else pass_cnt++;
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wr_before;
    wr_before = wr_count;
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    total_cnt++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'h0)
      $display("FAIL illegal_011: got lat=%0d err=%b rdata=%h expected 1/1/00000000", lat, er, rd);
    else pass_cnt++;
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, rd, er, lat);
    total_cnt++;
    if (lat != 1 || er !== 1'b1 || wr_count != wr_before)
      $display("FAIL illegal_store: got lat=%0d err=%b writes=%0d expected 1/1/%0d", lat, er, wr_count, wr_before);
    else pass_cnt++;
    do_req(1'b0, 3'b110, 32'h10, 32'h0, rd, er, lat);
    total_cnt++;
    if (lat != 1 || er !== 1'b1) $display("FAIL illegal_110: got lat=%0d err=%b expected 1/1", lat, er);
    else pass_cnt++;
    do_req(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    total_cnt++;
    if (er !== 1'b0 || rd !== 32'hFFFF_FFEF) $display("FAIL after_error: got err=%b rdata=%h expected 0/ffffffef", er, rd);
    else pass_cnt++;
  endtask

  task automatic test_top_word();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0BAD_F00D, rd, er, lat);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, rd, er, lat);
    total_cnt++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0BAD_F00D)
      $display("FAIL top_lw: got lat=%0d err=%b rdata=%h expected 2/0/0badf00d", lat, er, rd);
    else pass_cnt++;
    do_req(1'b0, 3'b101, 32'hFFFF_FFFE, 32'h0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'h0000_0BAD) $display("FAIL top_lhu: got %h expected 00000bad", rd);
    else pass_cnt++;
    do_req(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'h0000_000B) $display("FAIL top_lb: got %h expected 0000000b", rd);
    else pass_cnt++;
  endtask

  // req_valid stays high across four requests; each must be answered once,
  // in order, and req_ready must drop right after every acceptance.
  task automatic test_back_to_back();
    logic        b_we    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  b_f3    [4] = '{3'b010, 3'b010, 3'b111, 3'b100};
    logic [31:0] b_addr  [4] = '{32'h40, 32'h40, 32'h40, 32'h43};
    logic [31:0] b_wdata [4] = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
    logic [31:0] e_rdata [4] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h0000_00CA};
    logic        e_err   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int idx, nresp, bad_ready, extra;
    bit accepted_prev;
    idx = 0; nresp = 0; bad_ready = 0; extra = 0; accepted_prev = 1'b0;
    for (int cyc = 0; cyc < 60 && nresp < 4; cyc++) begin
      @(negedge clk);
      if (accepted_prev && req_ready) bad_ready++;
      if (resp_valid && req_ready) bad_ready++;
      if (resp_valid) begin
        total_cnt++;
        if (resp_rdata !== e_rdata[nresp] || resp_error !== e_err[nresp])
          $display("FAIL b2b_resp%0d: got rdata=%h err=%b expected %h/%b",
                   nresp, resp_rdata, resp_error, e_rdata[nresp], e_err[nresp]);
        else pass_cnt++;
        nresp++;
      end
      if (idx < 4) begin
        req_we = b_we[idx]; req_funct3 = b_f3[idx];
        req_addr = b_addr[idx]; req_wdata = b_wdata[idx];
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      accepted_prev = req_ready && req_valid;
      if (accepted_prev) idx++;
    end
    req_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    total_cnt++;
    if (nresp != 4 || extra != 0)
      $display("FAIL b2b_count: got %0d+%0d responses expected 4+0", nresp, extra);
    else pass_cnt++;
    total_cnt++;
    if (bad_ready != 0) $display("FAIL b2b_ready: got %0d busy-ready cycles expected 0", bad_ready);
    else pass_cnt++;
  endtask

  task automatic test_alignment_bus();
    total_cnt++;
    if (addr_viol != 0) $display("FAIL mem_addr_align: got %0d unaligned cycles expected 0", addr_viol);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_rmw();
    test_sw_lw();
    test_byte();
    test_half();
    test_misaligned();
    test_illegal();
    test_top_word();
    test_back_to_back();
    test_alignment_bus();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
